// File: rtl/spi_accel_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : accel_spi_pkg
// Purpose : Shared opcodes, register map and state type for the ADXL362-style
//           SPI register interface (responder and initiator both import it).
// Rev     : 1.0  initial release
// ============================================================================
package accel_spi_pkg;

  // Instruction bytes
  localparam logic [7:0] OP_WRITE = 8'h0A;
  localparam logic [7:0] OP_READ  = 8'h0B;

  // Register map (6-bit address space)
  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_XDATA     = 6'h08;
  localparam logic [5:0] ADDR_YDATA     = 6'h09;
  localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
  localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;

  // Transaction phases
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA_RD = 3'd3,
    ST_DATA_WR = 3'd4,
    ST_IGNORE  = 3'd5
  } state_t;

  // Measurement mode is POWER_CTL[1:0] == 2'b10
  function automatic logic is_measure(input logic [7:0] pwr);
    return (pwr[1:0] == 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_accel_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_accel_responder_if
// Purpose : 4-wire SPI bundle (mode 0). master = initiator side,
//           slave = responder side.
// Rev     : 1.0  initial release
// ============================================================================
interface spi_accel_responder_if;
  logic cs;    // active-low chip select
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs, output sclk, output mosi, input miso);
  modport slave  (input cs, input sclk, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/spi_accel_responder_pin_sync.sv
`default_nettype none
// ============================================================================
// Module  : spi_pin_sync
// Purpose : Multi-stage synchronizer for cs/sclk/mosi plus edge detection.
//           Chip select only becomes visible once it has been seen high after
//           reset, so a cs held low across reset never yields a falling edge.
// Rev     : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_cs,
  input  wire logic i_sclk,
  input  wire logic i_mosi,
  output logic      o_cs,
  output logic      o_mosi,
  output logic      o_sclk_rise,
  output logic      o_sclk_fall,
  output logic      o_cs_fall,
  output logic      o_cs_rise
);

  logic [SYNC_STAGES-1:0] r_cs_pipe;
  logic [SYNC_STAGES-1:0] r_sclk_pipe;
  logic [SYNC_STAGES-1:0] r_mosi_pipe;
  logic                   r_armed;
  logic                   r_cs_prev;
  logic                   r_sclk_prev;
  logic                   w_cs_lvl;

  // cs reads as deasserted until a synchronized high has been observed
  assign w_cs_lvl = r_cs_pipe[SYNC_STAGES-1] | ~r_armed;

  // Synchronizer chains and previous-level registers for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_pipe   <= '0;
      r_sclk_pipe <= '0;
      r_mosi_pipe <= '0;
      r_armed     <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_cs_pipe   <= {r_cs_pipe[SYNC_STAGES-2:0], i_cs};
      r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-2:0], i_sclk};
      r_mosi_pipe <= {r_mosi_pipe[SYNC_STAGES-2:0], i_mosi};
      r_armed     <= r_armed | r_cs_pipe[SYNC_STAGES-1];
      r_cs_prev   <= w_cs_lvl;
      r_sclk_prev <= r_sclk_pipe[SYNC_STAGES-1];
    end
  end

  assign o_cs        = w_cs_lvl;
  assign o_mosi      = r_mosi_pipe[SYNC_STAGES-1];
  assign o_sclk_rise = ~r_sclk_prev &  r_sclk_pipe[SYNC_STAGES-1];
  assign o_sclk_fall =  r_sclk_prev & ~r_sclk_pipe[SYNC_STAGES-1];
  assign o_cs_fall   =  r_cs_prev   & ~w_cs_lvl;
  assign o_cs_rise   = ~r_cs_prev   &  w_cs_lvl;

endmodule
`default_nettype wire

// File: rtl/spi_accel_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_accel_responder
// Purpose : Oversampled SPI target emulating the ADXL362 register interface:
//           instruction, address, then data bytes with 6-bit auto-increment.
//           Axis values are snapshotted at cs fall for coherent bursts.
// Rev     : 1.0  initial release
// ============================================================================
module spi_accel_responder
  import accel_spi_pkg::*;
#(
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  spi_accel_responder_if.slave   spi,
  input  wire logic [7:0]        i_x_axis,
  input  wire logic [7:0]        i_y_axis,
  input  wire logic [7:0]        i_z_axis,
  output logic [7:0]             o_power_ctl,
  output logic                   o_measure,
  output logic                   o_busy
);

  logic       w_cs, w_mosi, w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  state_t     r_state, w_state_next;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic [5:0] r_addr;
  logic       r_is_read;
  logic [7:0] r_sx, r_sy, r_sz;
  logic [7:0] r_power_ctl;
  logic       r_miso;
  logic       w_active, w_rise_q, w_fall_q, w_byte_done;
  logic [7:0] w_rx_byte;
  logic [5:0] w_rd_addr;
  logic [7:0] w_rd_data;
  logic       w_measure;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cs        (spi.cs),
    .i_sclk      (spi.sclk),
    .i_mosi      (spi.mosi),
    .o_cs        (w_cs),
    .o_mosi      (w_mosi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise)
  );

  // sclk edges count only inside a frame; a cs fall in the same cycle wins
  assign w_active    = ~w_cs & ~w_cs_fall & (r_state != ST_IDLE);
  assign w_rise_q    = w_sclk_rise & w_active;
  assign w_fall_q    = w_sclk_fall & w_active;
  assign w_byte_done = w_rise_q & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_sh, w_mosi};
  assign w_measure   = is_measure(r_power_ctl);

  // Read address: freshly received address in ADDR, else the next burst slot
  assign w_rd_addr = (r_state == ST_ADDR) ? w_rx_byte[5:0] : (r_addr + 6'd1);

  // Register file read mux
  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      ADDR_DEVID_AD:  w_rd_data = DEVID_AD;
      ADDR_DEVID_MST: w_rd_data = DEVID_MST;
      ADDR_PARTID:    w_rd_data = PARTID;
      ADDR_XDATA:     w_rd_data = w_measure ? r_sx : 8'h00;
      ADDR_YDATA:     w_rd_data = w_measure ? r_sy : 8'h00;
      ADDR_ZDATA:     w_rd_data = w_measure ? r_sz : 8'h00;
      ADDR_POWER_CTL: w_rd_data = r_power_ctl;
      default:        w_rd_data = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: cs edges dominate, otherwise advance at byte completion
  always_comb begin
    w_state_next = r_state;
    if (w_cs_rise) begin
      w_state_next = ST_IDLE;
    end else if (w_cs_fall) begin
      w_state_next = ST_CMD;
    end else if (w_byte_done) begin
      case (r_state)
        ST_CMD:  w_state_next = ((w_rx_byte == OP_READ) || (w_rx_byte == OP_WRITE))
                                ? ST_ADDR : ST_IGNORE;
        ST_ADDR: w_state_next = r_is_read ? ST_DATA_RD : ST_DATA_WR;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Datapath: shifting, address/burst handling, POWER_CTL write, miso
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_rx_sh     <= 7'd0;
      r_tx_sh     <= 8'd0;
      r_addr      <= 6'd0;
      r_is_read   <= 1'b0;
      r_sx        <= 8'd0;
      r_sy        <= 8'd0;
      r_sz        <= 8'd0;
      r_power_ctl <= 8'd0;
      r_miso      <= 1'b0;
    end else if (w_cs_rise) begin
      r_bit_cnt <= 3'd0;
      r_miso    <= 1'b0;
    end else if (w_cs_fall) begin
      r_sx      <= i_x_axis;
      r_sy      <= i_y_axis;
      r_sz      <= i_z_axis;
      r_bit_cnt <= 3'd0;
      r_miso    <= 1'b0;
    end else begin
      if (w_rise_q) begin
        r_rx_sh   <= w_rx_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_byte_done) begin
        case (r_state)
          ST_CMD: r_is_read <= (w_rx_byte == OP_READ);
          ST_ADDR: begin
            r_addr  <= w_rx_byte[5:0];
            r_tx_sh <= w_rd_data;
          end
          ST_DATA_RD: begin
            r_addr  <= r_addr + 6'd1;
            r_tx_sh <= w_rd_data;
          end
          ST_DATA_WR: begin
            if (r_addr == ADDR_POWER_CTL) r_power_ctl <= w_rx_byte;
            r_addr <= r_addr + 6'd1;
          end
          default: ;
        endcase
      end
      if (w_fall_q && (r_state == ST_DATA_RD)) begin
        r_miso  <= r_tx_sh[7];
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      end
    end
  end

  assign spi.miso    = r_miso;
  assign o_power_ctl = r_power_ctl;
  assign o_measure   = w_measure;
  assign o_busy      = ~w_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_accel_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_accel_responder
// Purpose : Self-checking bench: directed frames plus randomized bursts,
//           compared against a register-map model of the sensor.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_accel_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] x_axis, y_axis, z_axis;
  logic [7:0] power_ctl;
  logic       measure, busy;

  spi_accel_responder_if spi_if ();

  spi_accel_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi_if.slave),
    .i_x_axis    (x_axis),
    .i_y_axis    (y_axis),
    .i_z_axis    (z_axis),
    .o_power_ctl (power_ctl),
    .o_measure   (measure),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0] m_pwr = 8'h00;
  logic [7:0] m_sx = 8'h00, m_sy = 8'h00, m_sz = 8'h00;

  // Frame buffers
  logic [7:0] f_tx [0:7];
  logic [7:0] f_rx [0:7];
  logic [7:0] f_exp[0:7];

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a);
    logic meas;
    meas = (m_pwr[1:0] == 2'b10);
    case (a)
      6'h00:   return 8'hAD;
      6'h01:   return 8'h1D;
      6'h02:   return 8'hF2;
      6'h08:   return meas ? m_sx : 8'h00;
      6'h09:   return meas ? m_sy : 8'h00;
      6'h0A:   return meas ? m_sz : 8'h00;
      6'h2D:   return m_pwr;
      default: return 8'h00;
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 initiator: drive mosi, sample miso just before the rising edge
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_if.mosi = tx[i];
      wait_clk(8);
      rx[i] = spi_if.miso;
      spi_if.sclk = 1'b1;
      wait_clk(8);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_if.cs = 1'b0;
    m_sx = x_axis; m_sy = y_axis; m_sz = z_axis;
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(8);
    spi_if.cs = 1'b1;
    wait_clk(16);
  endtask

  // Full frame of n bytes from f_tx; expectations derived from the register map
  task automatic run_frame(input string name, input int n);
    logic [7:0] rx;
    logic [5:0] a;
    cs_begin();
    a = f_tx[1][5:0];
    for (int k = 0; k < n; k++)
      f_exp[k] = (f_tx[0] == 8'h0B && k >= 2) ? m_read(a + 6'(k - 2)) : 8'h00;
    for (int k = 0; k < n; k++) begin
      spi_xfer(f_tx[k], 8, rx);
      f_rx[k] = rx;
      if (k == 0) begin
        check8({name, "_busy"}, {7'd0, busy}, 8'h01);
        x_axis = 8'($urandom); y_axis = 8'($urandom); z_axis = 8'($urandom);
      end
    end
    cs_end();
    if (f_tx[0] == 8'h0A)
      for (int k = 2; k < n; k++)
        if (6'(a + 6'(k - 2)) == 6'h2D) m_pwr = f_tx[k];
    for (int k = 0; k < n; k++)
      check8($sformatf("%s_b%0d", name, k), f_rx[k], f_exp[k]);
    check8({name, "_pwr"}, power_ctl, m_pwr);
    check8({name, "_meas"}, {7'd0, measure}, {7'd0, (m_pwr[1:0] == 2'b10)});
    check8({name, "_idle"}, {6'd0, busy, spi_if.miso}, 8'h00);
  endtask

  task automatic set3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    f_tx[0] = b0; f_tx[1] = b1; f_tx[2] = b2;
    for (int k = 3; k < 8; k++) f_tx[k] = 8'h00;
  endtask

  initial begin
    logic [7:0] rx;
    int len;
    spi_if.cs = 1'b1; spi_if.sclk = 1'b0; spi_if.mosi = 1'b0;
    x_axis = 8'h00; y_axis = 8'h00; z_axis = 8'h00;
    wait_clk(4);
    check8("rst_pwr", power_ctl, 8'h00);
    check8("rst_flags", {5'd0, measure, busy, spi_if.miso}, 8'h00);
    rst_n = 1'b1;
    wait_clk(10);

    // Device ID burst
    set3(8'h0B, 8'h00, 8'h00);
    run_frame("read_id", 5);

    // Write POWER_CTL then read it back
    set3(8'h0A, 8'h2D, 8'h02);
    run_frame("wr_pwr", 3);
    set3(8'h0B, 8'h2D, 8'h00);
    run_frame("rd_pwr", 3);

    // Coherent axis burst (axes change after cs fall)
    x_axis = 8'h12; y_axis = 8'hF0; z_axis = 8'h7F;
    set3(8'h0B, 8'h08, 8'h00);
    run_frame("axis", 5);

    // Measure off hides axis data
    set3(8'h0A, 8'h2D, 8'h00);
    run_frame("pwr_off", 3);
    set3(8'h0B, 8'h08, 8'h00);
    run_frame("axis_off", 3);

    // Unknown opcode
    set3(8'h0D, 8'h2D, 8'h00);
    run_frame("bad_op", 4);

    // Abort mid data byte: POWER_CTL must be unchanged
    set3(8'h0A, 8'h2D, 8'h02);
    run_frame("pre_abort", 3);
    cs_begin();
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h2D, 8, rx);
    spi_xfer(8'hFF, 4, rx);
    cs_end();
    check8("abort_pwr", power_ctl, m_pwr);
    set3(8'h0B, 8'h2D, 8'h00);
    run_frame("post_abort", 3);

    // Address wrap 0x3F -> 0x00
    set3(8'h0B, 8'h3F, 8'h00);
    run_frame("wrap", 4);

    // Randomized frames
    for (int it = 0; it < 14; it++) begin
      x_axis = 8'($urandom); y_axis = 8'($urandom); z_axis = 8'($urandom);
      len = 3 + int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        f_tx[0] = 8'h0A;
        f_tx[1] = {2'($urandom), 6'($urandom_range(8'h2B, 8'h2D))};
        for (int k = 2; k < 8; k++)
          f_tx[k] = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'($urandom);
      end else begin
        f_tx[0] = 8'h0B;
        f_tx[1] = 8'($urandom);
        if ($urandom_range(0, 1) == 0) f_tx[1][5:0] = 6'($urandom_range(6'h3E, 6'h3F));
        if ($urandom_range(0, 1) == 0) f_tx[1][5:0] = 6'($urandom_range(6'h06, 6'h0A));
        for (int k = 2; k < 8; k++) f_tx[k] = 8'($urandom);
      end
      run_frame($sformatf("rnd%0d", it), len);
    end

    // Reset mid-frame, then cs held low must not start a new transaction
    set3(8'h0A, 8'h2D, 8'h02);
    run_frame("pre_rst", 3);
    cs_begin();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h2D, 8, rx);
    spi_xfer(8'h00, 3, rx);
    rst_n = 1'b0;
    #1;
    check8("rst_mid_pwr", power_ctl, 8'h00);
    check8("rst_mid_flags", {6'd0, busy, spi_if.miso}, 8'h00);
    m_pwr = 8'h00;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(8);
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h2D, 8, rx);
    spi_xfer(8'h03, 8, rx);
    check8("stale_cs_miso", rx, 8'h00);
    cs_end();
    check8("stale_cs_pwr", power_ctl, 8'h00);
    set3(8'h0B, 8'h2D, 8'h00);
    run_frame("post_rst", 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit
  initial begin
    #5ms;
    n_total++;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
